cfg_chain_ctrl: RTL and testbench

Serial configuration controller for a scan-style chain of CHAIN_LEN DFF_X1 flops in the standard-cell test and configuration datapath. It accepts parallel words over a valid/ready handshake and shifts them LSB-first into the chain, one bit per cycle. After exactly CHAIN_LEN bits it pulses an update strobe. It also reassembles the bits shifted out of the chain into readback words.

---
 rtl/cfg_chain_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_ctrl.sv
// cfg_chain_ctrl: loads host words LSB-first into a CHAIN_LEN-flop scan chain, then strobes update.
// Latency: first shift the cycle after accept; one bit per cycle; update the cycle after the last bit.
// Backpressure: req_ready only in IDLE/LOAD; readback (rd_valid/rd_data) has none.
//
// Ports:
//   CK, RN                       clock, async active-low reset
//   req_valid/req_ready/req_data host word handshake (bit 0 shifted first)
//   abort                        cancel current load, return to IDLE
//   shift_en, scan_in, scan_out  chain SE / SI / SO
//   update                       one-cycle strobe after CHAIN_LEN bits
//   busy                         state != IDLE
//   rd_valid, rd_data            readback words assembled from scan_out
// Build option: define READBACK_EN to build the scan_out capture path;
// otherwise rd_valid/rd_data are tied 0 and scan_out is ignored.
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_data,
  input  logic              abort,
  output logic              shift_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              update,
  output logic              busy,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  localparam int WCW = $clog2(WORD_W + 1);
  localparam int TCW = $clog2(CHAIN_LEN + 1);
  localparam logic [WCW-1:0] WORD_BITS  = WCW'(WORD_W);
  localparam logic [TCW-1:0] CHAIN_BITS = TCW'(CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOAD   = 2'd2,
    UPDATE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic              last_bit;   // this SHIFT edge moves the CHAIN_LEN-th bit
  logic              word_done;  // this SHIFT edge moves the last bit of the word

  logic req_ready_q, shift_en_q, scan_in_q, update_q, busy_q;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    last_bit  = 1'b0;
    word_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          sreg_d  = req_data;
          wcnt_d  = WORD_BITS;
          tcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d    = sreg_q >> 1;
        wcnt_d    = wcnt_q - 1'b1;
        tcnt_d    = tcnt_q + 1'b1;
        last_bit  = (tcnt_d == CHAIN_BITS);
        word_done = (wcnt_d == '0);
        // Chain full wins over word exhaustion: leftover word bits are dropped.
        if (last_bit) begin
          state_d = UPDATE;
        end else if (word_done) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // tcnt carries over so the chain length is counted across words.
        if (req_valid && req_ready_q) begin
          sreg_d  = req_data;
          wcnt_d  = WORD_BITS;
          state_d = SHIFT;
        end
      end
      UPDATE: begin
        tcnt_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort beats any accept or transition; the UPDATE pulse is already on the wire.
    if (abort) begin
      state_d = IDLE;
      wcnt_d  = '0;
      tcnt_d  = '0;
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      req_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      scan_in_q   <= 1'b0;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      req_ready_q <= (state_d == IDLE) || (state_d == LOAD);
      shift_en_q  <= (state_d == SHIFT);
      scan_in_q   <= (state_d == SHIFT) && sreg_d[0];
      update_q    <= (state_d == UPDATE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready = req_ready_q;
  assign shift_en  = shift_en_q;
  assign scan_in   = scan_in_q;
  assign update    = update_q;
  assign busy      = busy_q;

`ifdef READBACK_EN
  logic [WORD_W-1:0] rb_q, rb_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WCW-1:0]    rb_idx;

  always_comb begin
    rb_d       = rb_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    // Bit position within the readback word equals bits already shifted of this word.
    rb_idx     = WORD_BITS - wcnt_q;
    if (state_q == SHIFT && !abort) begin
      rb_d = rb_q | (WORD_W'(scan_out) << rb_idx);
      if (last_bit || word_done) begin
        rd_valid_d = 1'b1;
        rd_data_d  = rb_d;
        rb_d       = '0;
      end
    end
    // A partial word is discarded on abort.
    if (abort) begin
      rb_d = '0;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      rb_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rb_q       <= rb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
  assign rd_valid        = 1'b0;
  assign rd_data         = '0;
`endif

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Testbench for cfg_chain_ctrl (CHAIN_LEN=12, WORD_W=8) with a behavioural scan chain.
// Expected shift stream, final chain value, readback words and cycle counts come from
// plain arithmetic over the offered words and the preloaded chain contents.
module tb_cfg_chain_ctrl;

  localparam int CL = 12;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic          CK;
  logic          RN;
  logic          req_valid;
  logic          req_ready;
  logic [WW-1:0] req_data;
  logic          abort;
  logic          shift_en;
  logic          scan_in;
  logic          scan_out;
  logic          update;
  logic          busy;
  logic          rd_valid;
  logic [WW-1:0] rd_data;

  cfg_chain_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .CK        (CK),
    .RN        (RN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .abort     (abort),
    .shift_en  (shift_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .update    (update),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural chain: head takes scan_in, tail drives scan_out.
  logic [CL-1:0] chain;
  logic          pre_en;
  logic [CL-1:0] pre_val;
  always @(posedge CK) begin
    if (pre_en) chain <= pre_val;
    else if (shift_en) chain <= {chain[CL-2:0], scan_in};
  end
  assign scan_out = chain[CL-1];

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [WW-1:0] words[NW];
  int            stalls[NW];  // stalls[k]: cycles req_valid held low before word k (k>=1)

  task automatic run_load(input logic [CL-1:0] pre, input int abort_at);
    int            wi, nsh, upd, nbusy, nload, stall_left, post, stall_sum, exp_rd;
    bit            aborted, done;
    logic [CL-1:0] got_s, exp_s, exp_c;
    logic [WW-1:0] rdw[$];
    logic [WW-1:0] exp_w;
    logic [WW-1:0] cur_w;
    wi = 0; nsh = 0; upd = 0; nbusy = 0; nload = 0; stall_left = 0; post = 0;
    aborted = 1'b0; done = 1'b0; got_s = '0;
    @(negedge CK); pre_en = 1'b1; pre_val = pre;
    @(negedge CK); pre_en = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge CK);
      if (shift_en) begin
        if (nsh < CL) got_s[nsh] = scan_in;
        nsh++;
      end
      if (update) upd++;
      if (busy) nbusy++;
      if (busy && req_ready) nload++;
      if (rd_valid) rdw.push_back(rd_data);
      if (abort) begin
        chk("abort_shift_en", {31'd0, shift_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        abort = 1'b0;
        aborted = 1'b1;
        post = 4;
      end else if (aborted) begin
        post--;
        if (post == 0) done = 1'b1;
      end else begin
        if (abort_at > 0 && shift_en && nsh == abort_at) begin
          abort = 1'b1;
          req_valid = 1'b0;
        end else if (req_ready && wi < NW) begin
          if (busy && stall_left > 0) begin
            req_valid = 1'b0;
            stall_left--;
          end else begin
            req_valid = 1'b1;
            req_data = words[wi];
            wi++;
            if (wi < NW) stall_left = stalls[wi];
          end
        end else begin
          req_valid = 1'b0;
        end
        if (upd > 0 && !busy) done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) chk("timeout", 32'd0, 32'd1);
`ifdef READBACK_EN
    exp_rd = (abort_at > WW) ? 1 : 0;
`else
    exp_rd = 0;
`endif
    if (aborted) begin
      chk("abort_no_update", upd, 32'd0);
      chk("abort_rd_count", rdw.size(), exp_rd);
    end else begin
      stall_sum = 0;
      for (int k = 1; k < NW; k++) stall_sum += stalls[k];
      for (int k = 0; k < CL; k++) begin
        cur_w = words[k / WW];
        exp_s[k] = cur_w[k % WW];
        exp_c[CL-1-k] = cur_w[k % WW];
      end
      chk("shift_count", nsh, CL);
      chk("scan_in_stream", got_s, exp_s);
      chk("update_pulses", upd, 32'd1);
      chk("load_cycles", nload, (NW - 1) + stall_sum);
      chk("busy_cycles", nbusy, CL + (NW - 1) + stall_sum + 1);
      chk("final_chain", chain, exp_c);
`ifdef READBACK_EN
      chk("rd_count", rdw.size(), NW);
      for (int j = 0; j < NW; j++) begin
        exp_w = '0;
        for (int b = 0; b < WW; b++)
          if (j * WW + b < CL) exp_w[b] = pre[CL-1-(j*WW+b)];
        if (j < rdw.size()) chk("rd_word", rdw[j], exp_w);
      end
`else
      chk("rd_count_tied", rdw.size(), 32'd0);
      chk("rd_data_tied", rd_data, 32'd0);
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_asrt);
    $fatal(1, "watchdog");
  end

  initial begin
    int ucnt;
    RN = 1'b0; req_valid = 1'b0; req_data = '0; abort = 1'b0;
    pre_en = 1'b0; pre_val = '0;
    for (int k = 0; k < NW; k++) begin words[k] = '0; stalls[k] = 0; end

    // Reset state
    repeat (2) @(negedge CK);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_shift_en", {31'd0, shift_en}, 32'd0);
    chk("rst_scan_in", {31'd0, scan_in}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    RN = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(negedge CK);
    chk("ready_after_edge", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Two-word load, back-to-back, chain preloaded with all ones
    words[0] = 8'hA5; words[1] = 8'h03; stalls[1] = 0;
    run_load(12'hFFF, 0);

    // Abort on the third shift cycle, then a normal load
    words[0] = 8'h3C; words[1] = 8'h0A;
    run_load(12'h5A5, 3);
    words[0] = 8'h96; words[1] = 8'h07;
    run_load(12'h123, 0);

    // Stall five cycles in LOAD
    words[0] = 8'h5E; words[1] = 8'h09; stalls[1] = 5;
    run_load(12'hA0F, 0);

    // abort + req_valid in IDLE: no accept
    @(negedge CK);
    abort = 1'b1; req_valid = 1'b1; req_data = 8'h5A;
    @(negedge CK);
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_shift_en", {31'd0, shift_en}, 32'd0);
    chk("prio_ready", {31'd0, req_ready}, 32'd1);
    abort = 1'b0; req_valid = 1'b0;
    @(negedge CK);
    chk("prio_still_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a load
    req_valid = 1'b1; req_data = 8'hFF;
    @(negedge CK); req_valid = 1'b0;
    repeat (3) @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_shift_en", {31'd0, shift_en}, 32'd0);
    @(negedge CK); RN = 1'b1;
    ucnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CK);
      if (update || busy) ucnt++;
    end
    chk("midrst_quiet", ucnt, 32'd0);

    // Randomized loads, stalls and aborts
    for (int it = 0; it < 24; it++) begin
      int ab;
      for (int k = 0; k < NW; k++) begin
        words[k] = WW'($urandom);
        stalls[k] = $urandom_range(0, 3);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, CL - 1) : 0;
      run_load(CL'($urandom), ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
